// File: rtl/mdc_rdr_pkg.sv
// Shared widths, config-word layout and FSM state type for the MDC result reader.
package mdc_rdr_pkg;

  localparam int unsigned SIZEADDRESS = 12;
  localparam int unsigned SIZECOUNT   = 12;
  localparam int unsigned SIZEBURST   = 8;
  localparam int unsigned SIZEDATA    = 32;
  localparam int unsigned CONF_W      = SIZEADDRESS + SIZECOUNT + SIZEBURST;

  localparam int unsigned BASE_LSB  = 0;
  localparam int unsigned SIZE_LSB  = SIZEADDRESS;
  localparam int unsigned BURST_LSB = SIZEADDRESS + SIZECOUNT;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [SIZEBURST-1:0]   burst;
    logic [SIZECOUNT-1:0]   size;
    logic [SIZEADDRESS-1:0] base;
  } cfg_t;

  function automatic cfg_t get_cfg(input logic [CONF_W-1:0] word);
    cfg_t c;
    c.base  = word[BASE_LSB  +: SIZEADDRESS];
    c.size  = word[SIZE_LSB  +: SIZECOUNT];
    c.burst = word[BURST_LSB +: SIZEBURST];
    return c;
  endfunction

endpackage

// File: rtl/mdc_result_reader_if.sv
// Memory read port plus output stream of the result reader.
interface mdc_result_reader_if
  import mdc_rdr_pkg::*;
;
  logic [SIZEADDRESS-1:0] addressrd;
  logic                   enablerd;
  logic [SIZEDATA-1:0]    dataout;
  logic [SIZEDATA-1:0]    out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;

  modport master (
    output addressrd, enablerd, out_data, out_valid, out_last,
    input  dataout, out_ready
  );

  modport slave (
    input  addressrd, enablerd, out_data, out_valid, out_last,
    output dataout, out_ready
  );
endinterface

// File: rtl/mdc_sync_fifo.sv
// Synchronous FIFO with a registered head word; entries queue behind the head.
module mdc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] body_cnt;
  logic             pop_c;
  logic             head_free_c;
  logic             body_we_c;

  assign pop_c       = pop && head_valid;
  assign head_free_c = !head_valid || pop_c;
  // A push bypasses the body only when the head slot is free and nothing queues ahead.
  assign body_we_c   = push && !(head_free_c && (body_cnt == '0));

  always_ff @(posedge clk) begin
    if (body_we_c) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      head_valid <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      body_cnt   <= '0;
      count      <= '0;
    end else begin
      case ({push, pop_c})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
      if (body_we_c) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (head_free_c) begin
        if (body_cnt != '0) begin
          head       <= mem[rd_ptr];
          head_valid <= 1'b1;
          rd_ptr     <= PTR_W'(rd_ptr + 1'b1);
          if (!push) body_cnt <= CNT_W'(body_cnt - 1'b1);
        end else if (push) begin
          head       <= din;
          head_valid <= 1'b1;
        end else begin
          head_valid <= 1'b0;
        end
      end else if (push) begin
        body_cnt <= CNT_W'(body_cnt + 1'b1);
      end
    end
  end

endmodule

// File: rtl/mdc_result_reader.sv
// Reads a configured window of coprocessor local memory and streams it out with a last tag.
module mdc_result_reader
  import mdc_rdr_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CONF_W-1:0]   confin,
  input  logic                en,
  input  logic                start,
  mdc_result_reader_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t               state;
  cfg_t                 cfg_q;
  logic [SIZECOUNT-1:0] idx;
  logic [SIZEBURST-1:0] bcnt;
  logic                 rd_last_q;
  logic                 cap_q;
  logic                 cap_last_q;
  logic [SIZEDATA:0]    head;
  logic                 head_valid;
  logic [CNT_W-1:0]     fifo_count;

  cfg_t                 cfg_start_c;
  logic                 credit_c;
  logic                 issue_last_c;
  logic                 gap_c;
  logic                 pop_last_c;

  assign cfg_start_c  = en ? get_cfg(confin) : cfg_q;
  // Words already requested but not yet in the FIFO consume credit too.
  assign credit_c     = (32'(fifo_count) + 32'(bus.enablerd) + 32'(cap_q)) < FIFO_DEPTH;
  assign issue_last_c = (SIZECOUNT'(idx + 1'b1) == cfg_q.size);
  assign gap_c        = (cfg_q.burst != '0) && (bcnt == cfg_q.burst);
  assign pop_last_c   = head_valid && bus.out_ready && head[SIZEDATA];

  assign bus.out_data  = head[SIZEDATA-1:0];
  assign bus.out_last  = head[SIZEDATA];
  assign bus.out_valid = head_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cfg_q         <= '0;
      idx           <= '0;
      bcnt          <= '0;
      rd_last_q     <= 1'b0;
      cap_q         <= 1'b0;
      cap_last_q    <= 1'b0;
      bus.addressrd <= '0;
      bus.enablerd  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      cap_q        <= bus.enablerd;
      cap_last_q   <= rd_last_q;
      bus.enablerd <= 1'b0;
      rd_last_q    <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (en) cfg_q <= cfg_start_c;
          if (start) begin
            if (cfg_start_c.size == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              bus.addressrd <= cfg_start_c.base;
              bus.enablerd  <= 1'b1;
              idx           <= SIZECOUNT'(1);
              bcnt          <= SIZEBURST'(1);
              busy          <= 1'b1;
              rd_last_q     <= (cfg_start_c.size == SIZECOUNT'(1));
              state         <= (cfg_start_c.size == SIZECOUNT'(1)) ? DRAIN : READ;
            end
          end
        end
        READ: begin
          if (gap_c) begin
            bcnt <= '0;
          end else if (credit_c) begin
            bus.addressrd <= SIZEADDRESS'(cfg_q.base + SIZEADDRESS'(idx));
            bus.enablerd  <= 1'b1;
            idx           <= SIZECOUNT'(idx + 1'b1);
            bcnt          <= SIZEBURST'(bcnt + 1'b1);
            rd_last_q     <= issue_last_c;
            if (issue_last_c) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop_last_c) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mdc_sync_fifo #(
    .WIDTH (SIZEDATA + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (cap_q),
    .din        ({cap_last_q, bus.dataout}),
    .pop        (bus.out_ready),
    .head       (head),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_mdc_result_reader.sv
// Directed and randomized transfers against a queue-based model of the read-back window.
module tb_mdc_result_reader;
  import mdc_rdr_pkg::*;

  logic              clk;
  logic              rst;
  logic [CONF_W-1:0] confin;
  logic              en;
  logic              start;
  logic              busy;
  logic              done;

  mdc_result_reader_if bus ();

  mdc_result_reader #(.FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .confin (confin),
    .en     (en),
    .start  (start),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
  );

  int checks = 0;
  int errors = 0;

  logic [32:0] got_q[$];
  logic [11:0] rd_q[$];
  int          done_cnt;
  int          max_cnt;
  bit          prev_stall;
  logic [32:0] prev_word;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one-cycle read latency, mem[a] = a + 0x100.
  always @(posedge clk) begin
    if (bus.enablerd) bus.dataout <= 32'(bus.addressrd) + 32'h100;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream monitor, sampled after inputs settle and well away from the rising edge.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.out_valid), 64'(1));
        chk("stall_word", 64'({bus.out_last, bus.out_data}), 64'(prev_word));
      end
      if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_last, bus.out_data});
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_last, bus.out_data};
      if (bus.enablerd) rd_q.push_back(bus.addressrd);
      if (done) done_cnt++;
      if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
    end
  end

  function automatic logic ready_val(input int mode, input int cyc);
    if (mode == 1) return (cyc % 3) == 0;
    if (mode == 2) return 1'($urandom);
    return 1'b1;
  endfunction

  task automatic run(input logic [11:0] base, input logic [11:0] size, input logic [7:0] burst,
                     input int mode, input bit sep_en);
    logic [32:0] exp_q[$];
    logic [11:0] ea[$];
    bit          en_exp[$];
    bit          en_hist[$];
    logic [11:0] a;
    int          done_cyc;
    int          budget;
    int          n;
    n = int'(size);
    for (int i = 0; i < n; i++) begin
      a = base + 12'(i);
      ea.push_back(a);
      exp_q.push_back({(i == n - 1), 32'(a) + 32'h100});
      en_exp.push_back(1'b1);
      if (burst != 0 && ((i + 1) % int'(burst)) == 0 && i != n - 1) en_exp.push_back(1'b0);
    end
    got_q.delete();
    rd_q.delete();
    done_cnt = 0;
    max_cnt  = 0;

    @(negedge clk);
    confin    = {burst, size, base};
    en        = 1'b1;
    start     = !sep_en;
    bus.out_ready = ready_val(mode, 0);
    if (sep_en) begin
      @(negedge clk);
      en     = 1'b0;
      confin = CONF_W'($urandom);
      start  = 1'b1;
    end
    done_cyc = -1;
    budget   = 64 + 8 * n;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      en    = 1'b0;
      start = 1'b0;
      if (mode == 2 && cyc == 2 && n != 0) begin
        confin = CONF_W'($urandom);
        en     = 1'b1;
        start  = 1'b1;
      end
      bus.out_ready = ready_val(mode, cyc);
      if (mode == 0) en_hist.push_back(bus.enablerd);
      if (mode == 0 && burst == 0) begin
        chk("cyc_enablerd", 64'(bus.enablerd), 64'(cyc >= 1 && cyc <= n));
        if (cyc >= 1 && cyc <= n) chk("cyc_addr", 64'(bus.addressrd), 64'(ea[cyc-1]));
        chk("cyc_valid", 64'(bus.out_valid), 64'(cyc >= 3 && cyc <= n + 2));
        if (cyc >= 3 && cyc <= n + 2)
          chk("cyc_word", 64'({bus.out_last, bus.out_data}), 64'(exp_q[cyc-3]));
        chk("cyc_done", 64'(done), 64'((n == 0) ? (cyc == 1) : (cyc == n + 3)));
      end
      if (cyc == 1) chk("busy_start", 64'(busy), 64'(n != 0));
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", 64'(busy), 64'(0));
        break;
      end
    end
    chk("done_seen", 64'(done_cyc > 0), 64'(1));
    @(negedge clk);
    en    = 1'b0;
    start = 1'b0;
    chk("done_pulse", 64'(done), 64'(0));
    chk("done_count", 64'(done_cnt), 64'(1));
    chk("idle_valid", 64'(bus.out_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("word_count", 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) chk("word", 64'(got_q[i]), 64'(exp_q[i]));
    chk("read_count", 64'(rd_q.size()), 64'(n));
    for (int i = 0; i < n && i < rd_q.size(); i++) chk("read_addr", 64'(rd_q[i]), 64'(ea[i]));
    if (mode == 0) begin
      for (int i = 0; i < en_exp.size() && i < en_hist.size(); i++)
        chk("en_pattern", 64'(en_hist[i]), 64'(en_exp[i]));
      if (burst == 0) chk("done_cycle", 64'(done_cyc), 64'((n == 0) ? 1 : n + 3));
    end
    chk("fifo_bound", 64'(max_cnt <= 4), 64'(1));
  endtask

  initial begin
    rst           = 1'b1;
    en            = 1'b0;
    start         = 1'b0;
    confin        = '0;
    bus.out_ready = 1'b1;
    bus.dataout   = '0;
    repeat (3) @(negedge clk);
    chk("rst_addressrd", 64'(bus.addressrd), 64'(0));
    chk("rst_enablerd", 64'(bus.enablerd), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_last", 64'(bus.out_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_fifo", 64'(dut.fifo_count), 64'(0));
    rst = 1'b0;

    run(12'd10, 12'd4, 8'd0, 0, 1'b0);
    run(12'hFFE, 12'd4, 8'd0, 0, 1'b0);
    run(12'($urandom), 12'd4, 8'd2, 0, 1'b1);
    run(12'($urandom), 12'd8, 8'd0, 1, 1'b0);
    run(12'($urandom), 12'd0, 8'd0, 0, 1'b0);
    run(12'($urandom), 12'd5, 8'd3, 0, 1'b1);
    run(12'($urandom), 12'd1, 8'd1, 0, 1'b0);

    // Reset in cycle 4 of a size-8 transfer, then confirm the config was cleared.
    done_cnt = 0;
    @(negedge clk);
    confin = {8'd0, 12'd8, 12'h123};
    en     = 1'b1;
    start  = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      en    = 1'b0;
      start = 1'b0;
      if (cyc == 4) rst = 1'b1;
    end
    @(negedge clk);
    chk("mid_rst_enablerd", 64'(bus.enablerd), 64'(0));
    chk("mid_rst_addressrd", 64'(bus.addressrd), 64'(0));
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_out_data", 64'(bus.out_data), 64'(0));
    chk("mid_rst_out_last", 64'(bus.out_last), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_fifo", 64'(dut.fifo_count), 64'(0));
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_rst_no_done", 64'(done_cnt), 64'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cleared_cfg_done", 64'(done), 64'(1));
    chk("cleared_cfg_noread", 64'(bus.enablerd), 64'(0));
    repeat (2) @(negedge clk);

    run(12'($urandom), 12'd8, 8'd0, 0, 1'b0);
    for (int k = 0; k < 8; k++)
      run(12'($urandom), 12'($urandom_range(1, 12)), 8'($urandom_range(0, 3)),
          (k % 2 == 0) ? 2 : 0, 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdc_result_reader.md
# mdc_result_reader

Read-back engine for the MDC coprocessor local memory, working opposite the host-side write path. The host loads a packed configuration word and pulses start. The block then issues read requests on the memory read port (`addressrd`/`enablerd`), captures `dataout` after the fixed one-cycle read latency, and delivers the results on a valid/ready stream to the host or AXI bridge. It sits between the coprocessor memory read port and the platform output interface.

## Interface
- SIZEADDRESS, 12, local memory address width
- SIZECOUNT, 12, transfer size field width
- SIZEBURST, 8, burst field width
- SIZEDATA, 32, data width
- FIFO_DEPTH, 4, output buffer depth (power of two, ≥2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- confin  in  SIZEADDRESS+SIZECOUNT+SIZEBURST  config word: [SIZEADDRESS-1:0] baseaddr, next SIZECOUNT bits size, top SIZEBURST bits burst
- en  in  1  config load strobe
- start  in  1  start pulse
- addressrd  out  SIZEADDRESS  memory read address
- enablerd  out  1  memory read enable
- dataout  in  SIZEDATA  memory read data, valid the cycle after enablerd
- out_data  out  SIZEDATA  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_last  out  1  marks final word
- busy  out  1  high from start accept to done
- done  out  1  one-cycle pulse at completion

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: `en=1` loads the config register. `start=1` accepts a transfer.
  - `en` and `start` in the same cycle: the transfer uses the new `confin`.
  - Accepted transfer with size≠0 → READ.
  - Accepted transfer with size=0 → DONE. No reads are issued.
- `en` and `start` outside IDLE are ignored.
- READ: issue a read when `fifo_count + inflight < FIFO_DEPTH`.
  - Read address = `baseaddr + idx`, modulo 2^SIZEADDRESS (wraps 0xFFF→0x000).
  - idx counts 0..size-1.
  - burst≠0: after every `burst` issued reads, insert exactly one idle cycle (`enablerd=0`). burst=0: no gaps.
  - After the last read is issued → DRAIN.
- Capture: `inflight` is a 1-bit flag set in the cycle `enablerd=1`. In the next cycle, `dataout` is pushed into the FIFO.
- DRAIN: wait until the FIFO is empty and the last word has been handshaken → DONE.
- DONE: `done=1` for one cycle → IDLE.
- `out_last=1` with the word whose index is size-1.
- Stream rules:
  - A word transfers when `out_valid && out_ready`.
  - `out_data` and `out_last` stay stable while `out_valid=1 && out_ready=0`.
  - `out_valid` never drops without a handshake.
- `busy` is high in READ and DRAIN, and low in IDLE and DONE.
- `rst` mid-transfer: in-flight and buffered words are discarded, no `done` is generated, and the block returns to IDLE. The config register is cleared to 0.

## Timing
- Reset values:
  - addressrd=0, enablerd=0
  - out_data=0, out_valid=0, out_last=0
  - busy=0, done=0
  - FIFO empty, state IDLE
- start sampled at edge 0 → `enablerd=1`, `addressrd=baseaddr` in cycle 1 → `dataout` valid in cycle 2, pushed at end of cycle 2 → `out_valid=1` in cycle 3.
- Throughput: with `out_ready` held high and burst=0, one word per cycle. For a size-N transfer, the last handshake occurs in cycle N+2 and `done` is in cycle N+3.
- Backpressure: the credit rule guarantees no FIFO overflow. A FIFO push and pop in the same cycle are both performed, and the count is unchanged.
- `addressrd` and `enablerd` are registered outputs. `out_*` comes directly from the FIFO head register.

## Structure
- Package `mdc_rdr_pkg`:
  - state enum (IDLE/READ/DRAIN/DONE)
  - config field offsets: BASE_LSB=0, SIZE_LSB=SIZEADDRESS, BURST_LSB=SIZEADDRESS+SIZECOUNT
  - function for field extraction
- Sub-module `mdc_sync_fifo`:
  - parameterised width and depth
  - registered head, push/pop, count output
  - synchronous active-high reset
  - instantiated once for the output buffer
- Top level holds the FSM, idx counter, burst counter, inflight flag, and last-tag tracking. The last tag is one extra FIFO bit, so the FIFO width is SIZEDATA+1.

## Test plan
- Memory model: one-cycle read latency, mem[a]=a+0x100.
- base=10, size=4, burst=0, `out_ready=1`, start → addressrd 10,11,12,13 in cycles 1–4. Outputs 0x10A..0x10D in cycles 3–6, `out_last` on 0x10D, `done` in cycle 7.
- base=0xFFE, size=4 → addresses 0xFFE,0xFFF,0x000,0x001. Data 0x10FE,0x10FF,0x100,0x101.
- size=4, burst=2 → enablerd pattern 1,1,0,1,1. All 4 words are delivered in order.
- size=8, `out_ready` toggling 1,0,0,1,… → no loss or duplication. Data holds stable while stalled. FIFO count never exceeds 4.
- size=0 start → no enablerd, `done` pulse in cycle 1, no out_valid. `en`+`start` in the same cycle uses the new config.
- `rst` asserted in cycle 4 of a size=8 transfer → all outputs at reset values next cycle, no `done`. A new transfer afterwards completes normally.
